// File: rtl/snake_pkg.sv
// Shared command codes, FSM state encodings and direction helpers
// for the snake movement controller.
package snake_pkg;

  typedef enum logic [2:0] {
    CMD_NONE  = 3'd0,
    CMD_UP    = 3'd1,
    CMD_DOWN  = 3'd2,
    CMD_LEFT  = 3'd3,
    CMD_RIGHT = 3'd4,
    CMD_PAUSE = 3'd5
  } cmd_e;

  typedef enum logic [2:0] {
    ST_INICIO = 3'd0,
    ST_M_ARR  = 3'd1,
    ST_M_ABA  = 3'd2,
    ST_M_IZQ  = 3'd3,
    ST_M_DER  = 3'd4,
    ST_PAUSA  = 3'd5
  } state_e;

  function automatic logic is_dir(input logic [2:0] code);
    return (code >= CMD_UP) && (code <= CMD_RIGHT);
  endfunction

  function automatic logic [2:0] opposite_dir(input logic [2:0] code);
    case (code)
      CMD_UP:    return CMD_DOWN;
      CMD_DOWN:  return CMD_UP;
      CMD_LEFT:  return CMD_RIGHT;
      CMD_RIGHT: return CMD_LEFT;
      default:   return CMD_NONE;
    endcase
  endfunction

  // Direction code to movement state; anything else lands in INICIO.
  function automatic state_e dir_state(input logic [2:0] code);
    case (code)
      CMD_UP:    return ST_M_ARR;
      CMD_DOWN:  return ST_M_ABA;
      CMD_LEFT:  return ST_M_IZQ;
      CMD_RIGHT: return ST_M_DER;
      default:   return ST_INICIO;
    endcase
  endfunction

  function automatic logic [2:0] state_dir(input state_e st);
    case (st)
      ST_M_ARR: return CMD_UP;
      ST_M_ABA: return CMD_DOWN;
      ST_M_IZQ: return CMD_LEFT;
      ST_M_DER: return CMD_RIGHT;
      default:  return CMD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/snake_cmd_fifo.sv
// Small synchronous command FIFO; a push into a full FIFO is accepted
// only when a pop happens in the same cycle.
module snake_cmd_fifo #(
  parameter int FIFO_DEPTH = 4,
  parameter int CODE_W     = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [CODE_W-1:0]             din,
  output logic [CODE_W-1:0]             dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  logic [CODE_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (level == LW'(FIFO_DEPTH));
  assign empty   = (level == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/snake_dir_ctrl.sv
// Snake direction controller: buffered commands, internal movement tick,
// reversal rejection and pause/resume.
//   state     | meaning
//   INICIO    | not yet moving, waiting for a first direction
//   M_ARR     | moving up
//   M_ABA     | moving down
//   M_IZQ     | moving left
//   M_DER     | moving right
//   PAUSA     | paused, saved_q holds the direction to resume to
module snake_dir_ctrl
  import snake_pkg::*;
#(
  parameter int TICK_CYCLES = 2000000,
  parameter int FIFO_DEPTH  = 4,
  parameter int CODE_W      = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  input  logic [CODE_W-1:0]            cmd_code,
  input  logic [1:0]                   speed_sel,
  input  logic                         run_en,
  output logic [CODE_W-1:0]            accion,
  output logic                         mover,
  output logic                         paused,
  output logic                         dropped,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level
);
  localparam int CNT_W = $clog2(TICK_CYCLES);

  logic [CNT_W-1:0]  count_q;
  logic [31:0]       period_raw;
  logic [31:0]       period;
  logic              tick;
  logic              cmd_ok;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [CODE_W-1:0] fifo_dout;
  logic [2:0]        head;
  state_e            state_q, state_d;
  logic [2:0]        saved_q, saved_d;

  assign period_raw = 32'(TICK_CYCLES) >> speed_sel;
  assign period     = (period_raw < 32'd2) ? 32'd2 : period_raw;
  // Compare with >= so a shortened period fires on the very next cycle.
  assign tick       = run_en && (32'(count_q) >= (period - 32'd1));

  assign cmd_ok   = cmd_valid && (cmd_code >= CODE_W'(CMD_UP)) && (cmd_code <= CODE_W'(CMD_PAUSE));
  assign fifo_pop = tick && !fifo_empty;
  assign head     = fifo_empty ? 3'(CMD_NONE) : fifo_dout[2:0];

  snake_cmd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CODE_W     (CODE_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_ok),
    .pop   (fifo_pop),
    .din   (cmd_code),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_comb begin
    state_d = state_q;
    saved_d = saved_q;
    case (state_q)
      ST_INICIO: if (is_dir(head)) state_d = dir_state(head);
      ST_M_ARR, ST_M_ABA, ST_M_IZQ, ST_M_DER: begin
        if (head == CMD_PAUSE) begin
          saved_d = state_dir(state_q);
          state_d = ST_PAUSA;
        end else if (is_dir(head) && (head != state_dir(state_q)) &&
                     (head != opposite_dir(state_dir(state_q)))) begin
          state_d = dir_state(head);
        end
      end
      ST_PAUSA:  if (head == CMD_PAUSE) state_d = dir_state(saved_q);
      default:   state_d = ST_INICIO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      state_q <= ST_INICIO;
      saved_q <= '0;
      accion  <= '0;
      mover   <= 1'b0;
      paused  <= 1'b0;
      dropped <= 1'b0;
    end else begin
      dropped <= cmd_ok && fifo_full && !fifo_pop;
      mover   <= tick;
      if (tick) begin
        count_q <= '0;
        state_q <= state_d;
        saved_q <= saved_d;
        accion  <= CODE_W'(state_dir(state_d));
        paused  <= (state_d == ST_PAUSA);
      end else if (run_en) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Bench for snake_dir_ctrl: directed scenarios plus random traffic, all
// compared every cycle against a queue-based behavioural model.
module tb_snake_dir_ctrl;
  localparam int TICK = 16;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic [1:0] speed_sel;
  logic       run_en;
  logic [2:0] accion;
  logic       mover;
  logic       paused;
  logic       dropped;
  logic [2:0] fifo_level;

  int checks = 0;
  int errors = 0;

  snake_dir_ctrl #(.TICK_CYCLES(TICK), .FIFO_DEPTH(DEPTH), .CODE_W(3)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .speed_sel(speed_sel), .run_en(run_en), .accion(accion), .mover(mover),
    .paused(paused), .dropped(dropped), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  // Behavioural model: direction as a plain number, axis test for reversals.
  int mq[$];
  int m_cnt, m_dir, m_saved;
  bit m_pau;
  int m_accion;
  bit m_mover, m_paused, m_dropped;

  function automatic int period_now();
    int p = TICK >> speed_sel;
    return (p < 2) ? 2 : p;
  endfunction

  function automatic bit will_tick();
    return run_en && (m_cnt >= period_now() - 1);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_cnt = 0; m_dir = 0; m_saved = 0; m_pau = 0;
    m_accion = 0; m_mover = 0; m_paused = 0; m_dropped = 0;
  endtask

  task automatic model_step(input bit v, input int c);
    bit t = will_tick();
    int head = 0;
    m_dropped = 0;
    if (t && mq.size() > 0) head = mq.pop_front();
    if (v && c >= 1 && c <= 5) begin
      if (mq.size() < DEPTH) mq.push_back(c);
      else m_dropped = 1;
    end
    m_cnt = t ? 0 : (run_en ? m_cnt + 1 : m_cnt);
    m_mover = t;
    if (t) begin
      if (m_pau) begin
        if (head == 5) begin m_pau = 0; m_dir = m_saved; end
      end else if (m_dir == 0) begin
        if (head >= 1 && head <= 4) m_dir = head;
      end else if (head == 5) begin
        m_saved = m_dir; m_dir = 0; m_pau = 1;
      end else if (head >= 1 && head <= 4 && ((head <= 2) != (m_dir <= 2))) begin
        m_dir = head;
      end
      m_accion = m_dir;
      m_paused = m_pau;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit v, input int c);
    cmd_valid = v;
    cmd_code  = 3'(c);
    model_step(v, c);
    @(negedge clk);
    chk("accion", 32'(accion), 32'(m_accion));
    chk("mover", 32'(mover), 32'(m_mover));
    chk("paused", 32'(paused), 32'(m_paused));
    chk("dropped", 32'(dropped), 32'(m_dropped));
    chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    chk("rst_level", 32'(fifo_level), 0);
    chk("rst_accion", 32'(accion), 0);
    chk("rst_mover", 32'(mover), 0);
    chk("rst_paused", 32'(paused), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_to_tick(output int n);
    n = 0;
    do begin
      cyc(0, 0);
      n++;
    end while (!mover && n < 200);
    if (n >= 200) chk("tick_timeout", 32'(mover), 1);
  endtask

  int n, cnt;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_code = '0; speed_sel = 2'd0; run_en = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-tick with three entries buffered.
    cyc(1, 1); cyc(1, 2); cyc(1, 3);
    chk("pre_rst_level", 32'(fifo_level), 3);
    do_reset();

    // Start and reversal; first tick lands 16 cycles after release.
    cyc(1, 4);
    run_to_tick(n);
    chk("first_tick_cycle", 32'(n + 1), 16);
    chk("start_accion", 32'(accion), 4);
    cyc(0, 0);
    cyc(1, 3);
    run_to_tick(n);
    chk("reversal_accion", 32'(accion), 4);
    chk("reversal_level", 32'(fifo_level), 0);

    // Turn queueing from M_DER.
    cyc(1, 1); cyc(1, 3);
    run_to_tick(n); chk("turn1", 32'(accion), 1);
    run_to_tick(n); chk("turn2", 32'(accion), 3);
    run_to_tick(n); chk("turn3", 32'(accion), 3);

    // Pause/resume from M_ABA.
    cyc(1, 2);
    run_to_tick(n); chk("to_down", 32'(accion), 2);
    cyc(1, 5); cyc(1, 1); cyc(1, 5);
    run_to_tick(n); chk("pause_acc", 32'(accion), 0); chk("pause_flag", 32'(paused), 1);
    run_to_tick(n); chk("discard_acc", 32'(accion), 0); chk("discard_flag", 32'(paused), 1);
    run_to_tick(n); chk("resume_acc", 32'(accion), 2); chk("resume_flag", 32'(paused), 0);

    // Overflow with the tick frozen, then a push coinciding with the pop.
    run_en = 1'b0;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(1, 1);
      if (dropped) cnt++;
    end
    chk("ovf_level", 32'(fifo_level), 4);
    chk("ovf_drops", 32'(cnt), 2);
    run_en = 1'b1;
    for (int i = 0; i < 40 && !will_tick(); i++) cyc(0, 0);
    cyc(1, 1);
    chk("tickpush_mover", 32'(mover), 1);
    chk("tickpush_dropped", 32'(dropped), 0);
    chk("tickpush_level", 32'(fifo_level), 4);
    for (int i = 0; i < 4; i++) run_to_tick(n);
    chk("drain_level", 32'(fifo_level), 0);
    chk("drain_accion", 32'(accion), 2);

    // Speed select and freeze.
    speed_sel = 2'd2;
    run_to_tick(n);
    run_to_tick(n);
    chk("speed2_period", 32'(n), 4);
    speed_sel = 2'd0;
    run_to_tick(n);
    for (int i = 0; i < 10; i++) cyc(0, 0);
    speed_sel = 2'd2;
    run_to_tick(n);
    chk("shorten_tick", 32'(n), 1);
    speed_sel = 2'd0;
    run_en = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(0, 0);
      if (mover) cnt++;
    end
    chk("freeze_movers", 32'(cnt), 0);
    run_en = 1'b1;

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom % 50 == 0) speed_sel = 2'($urandom_range(0, 3));
      if ($urandom % 40 == 0) run_en = ($urandom % 4 != 0);
      if ($urandom % 600 == 0) do_reset();
      cyc(($urandom % 3) == 0, int'($urandom_range(0, 7)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/snake_dir_ctrl.md
Name: snake_dir_ctrl

Overview:
- Parametrised successor of the snake movement FSM; sits between input debouncing/encoding and the GameLogic painter.
- Buffers button command codes in a small FIFO and generates the movement tick internally, with a run-time selectable speed.
- Consumes at most one command per tick. Rejects reversals, handles pause/resume, and outputs the movement code (accion) plus a one-cycle move strobe.

Parameters:
- TICK_CYCLES, 2000000, base clock cycles per movement tick at speed_sel=0 (>=16).
- FIFO_DEPTH, 4, command buffer entries (power of two, >=2).
- CODE_W, 3, command/action code width.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- cmd_valid  in  1  one-cycle strobe: cmd_code is to be enqueued
- cmd_code  in  CODE_W  0 none, 1 up, 2 down, 3 left, 4 right, 5 pause
- speed_sel  in  2  tick period = TICK_CYCLES >> speed_sel
- run_en  in  1  0 freezes the tick counter; FIFO still accepts commands
- accion  out  CODE_W  current movement code (0 none, 1-4 direction)
- mover  out  1  one-cycle strobe, asserted when accion is updated for a tick
- paused  out  1  high while in a paused state
- dropped  out  1  one-cycle strobe, asserted when a valid command is lost because the FIFO is full
- fifo_level  out  clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset (async, any time): FSM=INICIO, accion=0, mover=0, paused=0, dropped=0, FIFO empty, tick counter=0, saved_dir=0.
- Enqueue rule: cmd_valid with code 1..5 is pushed; codes 0, 6 and 7 are ignored and never pushed or dropped.
- Full FIFO: a push is discarded and dropped pulses for 1 cycle.
  - Exception: if a pop happens in the same cycle, the push is accepted and level stays unchanged.
- Tick counter:
  - Increments while run_en=1.
  - Tick fires on the cycle where count >= period-1; the counter then clears to 0.
  - If speed_sel shortens the period below the current count, the tick fires on the next cycle.
  - run_en=0 holds the count.
- On a tick cycle T:
  - The FIFO head is popped if non-empty; if empty, the head is treated as code 0 and nothing is popped.
  - The FSM evaluates the head.
  - At T+1: accion/state/paused are updated and mover=1 for exactly that cycle.
  - mover is never asserted otherwise.
- States: INICIO, M_ARR, M_ABA, M_IZQ, M_DER, PAUSA.
  - saved_dir holds the direction to resume to.
- INICIO:
  - Codes 1-4 go to the matching M_* state with accion=code.
  - Codes 0 and 5 stay in INICIO with accion=0.
- M_ARR/M_ABA:
  - Codes 0, 1, 2 keep the current direction (reversal rejected).
  - Codes 3 and 4 go to M_IZQ/M_DER.
  - Code 5 goes to PAUSA: saved_dir=current, accion=0.
- M_IZQ/M_DER:
  - Codes 0, 3, 4 keep the current direction.
  - Codes 1 and 2 go to M_ARR/M_ABA.
  - Code 5 goes to PAUSA.
- PAUSA:
  - paused=1 and accion=0.
  - Codes 0-4 are consumed and discarded.
  - Code 5 returns to the M_* state for saved_dir, with accion=saved_dir and paused=0.
- Rejected or discarded commands are still popped: exactly one FIFO entry is consumed per tick.
- Illegal state encoding: recover to INICIO on the next tick with accion=0.
- Arithmetic: counter width is clog2(TICK_CYCLES). Period shift is a logical right shift; the period is never below 2.

Decomposition:
- snake_pkg holds:
  - command codes (CMD_NONE..CMD_PAUSE)
  - FSM state encodings
  - the opposite-direction function used for reversal rejection
- One sub-module: snake_cmd_fifo, a synchronous FIFO parametrised by FIFO_DEPTH and CODE_W, with push/pop/full/empty/level outputs.
- The tick generator and FSM stay in snake_dir_ctrl.

Test Plan:
- Setup for all cases: TICK_CYCLES=16, FIFO_DEPTH=4.
- Reset: rst pulse mid-tick with FIFO level 3 -> level=0, accion=0, mover=0 immediately; first tick fires at cycle 16 after release.
- Start and reversal: push 4, tick -> accion=4, mover 1 cycle; push 3, tick -> accion stays 4, level 0.
- Turn queueing: push 1 then 3 in consecutive cycles, during run in state M_DER -> tick1 accion=1, tick2 accion=3, tick3 accion=3.
- Pause/resume: in M_ABA push 5, 1, 5 -> ticks give accion 0 (paused=1), 0, then 2 (paused=0).
- Overflow: 6 pushes of code 1 with no tick -> level=4, dropped pulses twice; push coinciding with the tick-pop accepted without dropped.
- Speed and freeze:
  - speed_sel=2 -> ticks every 4 cycles.
  - Switch to 2 at count 10 under speed_sel=0 -> tick the next cycle.
  - run_en=0 for 20 cycles -> no mover.
